// File: rtl/request_latch_arbiter_8.sv
// request_latch_arbiter_8
//
// Purpose:
//   Latches rising edges on eight request lines into a sticky pending
//   vector. A two-state FSM grants the pending requests one at a time, using
//   fixed priority (bit 7 highest). A grant ends when the consumer
//   acknowledges it, or when it expires after ACK_TIMEOUT cycles without an
//   acknowledge. At least one idle cycle always separates two grants.
//
// Parameters:
//   ACK_TIMEOUT  maximum number of cycles a grant is held without i_ack.
//                The legal range is 1..15.
//
// Optional feature:
//   REQ_MASK_EN  When this macro is defined, the input i_mask is added. A
//                pending bit whose mask bit is 1 still latches and still
//                shows on o_pending, but it is not eligible for a grant.
//
// Ports:
//   i_clk      clock; all state updates on the rising edge
//   i_rst      synchronous, active-high reset
//   i_req      [7:0] request lines; a 0->1 transition posts a request
//   i_ack      consumer acknowledge of the current grant
//   i_mask     [7:0] eligibility mask (REQ_MASK_EN builds only)
//   o_valid    the grant on o_code is valid
//   o_code     [2:0] index of the granted request
//   o_pending  [7:0] registered pending-request vector
//   o_timeout  high during the last cycle of a grant that expires unacked

module request_latch_arbiter_8 #(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req,
  input  logic       i_ack,
`ifdef REQ_MASK_EN
  input  logic [7:0] i_mask,
`endif
  output logic       o_valid,
  output logic [2:0] o_code,
  output logic [7:0] o_pending,
  output logic       o_timeout
);

  localparam logic [3:0] LAST_WAIT = 4'(ACK_TIMEOUT - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg;
  logic [7:0] req_q_reg;
  logic [7:0] pending_reg;
  logic [7:0] pending_next;
  logic [7:0] rise;
  logic [7:0] clear_vec;
  logic [7:0] eligible;
  logic       arm_reg;
  logic [3:0] wait_reg;
  logic       valid_reg;
  logic [2:0] code_reg;
  logic [2:0] top_idx;
  logic       any_eligible;
  logic       grant_ack;
  logic       grant_expire;

  // req_q is cleared by reset. Because of that, the first cycle after reset
  // only primes req_q and does not detect edges. A line that is already high
  // when reset is released must fall and rise again before it posts.
  assign rise = arm_reg ? (i_req & ~req_q_reg) : 8'h00;

`ifdef REQ_MASK_EN
  assign eligible = pending_reg & ~i_mask;
`else
  assign eligible = pending_reg;
`endif

  assign grant_ack    = (state_reg == GRANT) && i_ack;
  assign grant_expire = (state_reg == GRANT) && !i_ack && (wait_reg == LAST_WAIT);

  // Update for each pending bit. A clear comes from an ack or an expiry of
  // the current grant. If a new edge arrives in the same cycle, the set wins.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pending
      assign clear_vec[gi]    = (grant_ack || grant_expire) && (code_reg == 3'(gi));
      assign pending_next[gi] = (pending_reg[gi] & ~clear_vec[gi]) | rise[gi];
    end
  endgenerate

  // Fixed-priority encoder. The loop scans upward, so the highest set bit
  // is the one that remains in top_idx.
  always_comb begin
    top_idx      = 3'd0;
    any_eligible = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) begin
        top_idx      = 3'(i);
        any_eligible = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= IDLE;
      req_q_reg   <= 8'h00;
      pending_reg <= 8'h00;
      arm_reg     <= 1'b0;
      wait_reg    <= 4'd0;
      valid_reg   <= 1'b0;
      code_reg    <= 3'd0;
    end else begin
      req_q_reg   <= i_req;
      arm_reg     <= 1'b1;
      pending_reg <= pending_next;
      case (state_reg)
        IDLE: begin
          // i_ack is ignored here. Only the registered pending vector is
          // used, so a new edge needs one more cycle before it is granted.
          if (any_eligible) begin
            state_reg <= GRANT;
            valid_reg <= 1'b1;
            code_reg  <= top_idx;
            wait_reg  <= 4'd0;
          end
        end
        GRANT: begin
          // code_reg holds its value for the whole grant, even if a request
          // with higher priority or a mask change arrives meanwhile.
          if (grant_ack || grant_expire) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            code_reg  <= 3'd0;
            wait_reg  <= 4'd0;
          end else begin
            wait_reg <= wait_reg + 4'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          code_reg  <= 3'd0;
        end
      endcase
    end
  end

  assign o_valid   = valid_reg;
  assign o_code    = code_reg;
  assign o_pending = pending_reg;
  // The expiry pulse is high during the last valid cycle of the grant. It
  // depends on i_ack in that cycle, because an ack that arrives in time
  // wins over the expiry. Reset masks it, so an abandoned grant never pulses.
  assign o_timeout = grant_expire & ~i_rst;

endmodule

// File: tb/tb_request_latch_arbiter_8.sv
// Testbench for request_latch_arbiter_8 (built with ACK_TIMEOUT = 4).
// Directed stimulus pushes expected grants {code, duration, timeout} into a
// queue. A monitor at the falling edge pops one entry for each grant it sees
// and compares the entry with the observed grant.

module tb_request_latch_arbiter_8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       ack;
  logic       o_valid;
  logic [2:0] o_code;
  logic [7:0] o_pending;
  logic       o_timeout;
`ifdef REQ_MASK_EN
  logic [7:0] mask;
`endif

  request_latch_arbiter_8 #(.ACK_TIMEOUT(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_ack     (ack),
`ifdef REQ_MASK_EN
    .i_mask    (mask),
`endif
    .o_valid   (o_valid),
    .o_code    (o_code),
    .o_pending (o_pending),
    .o_timeout (o_timeout)
  );

  typedef struct {
    logic [2:0] code;
    int         dur;  // 0 means the grant is abandoned by reset; not checked
    bit         to;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] code, input int dur, input bit to);
    exp_t e;
    e.code = code;
    e.dur  = dur;
    e.to   = to;
    exp_q.push_back(e);
    $display("expect grant code=%0d dur=%0d timeout=%0d", code, dur, to);
  endtask

  task automatic wait_valid(input int level);
    int n;
    n = 0;
    while (o_valid !== level[0] && n < 50) begin
      tick();
      n++;
    end
    if (o_valid !== level[0]) begin
      errors++;
      $display("FAIL wait_valid actual=%0b expected=%0d (cycle budget expired)", o_valid, level);
    end
  endtask

  // Wait for a grant, keep ack low for n-1 cycles, then ack for one cycle.
  // The grant is therefore valid for n cycles.
  task automatic grant_ack(input int n);
    wait_valid(1);
    repeat (n - 1) tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Monitor
  bit         in_grant = 0;
  int         dur_cnt  = 0;
  int         to_at    = 0;
  logic [2:0] held_code;
  exp_t       cur;

  always @(negedge clk) begin
    if (rst) begin
      in_grant = 0;
    end else begin
      if (o_timeout && !o_valid) check("timeout_outside_grant", 1, 0);
      if (o_valid) begin
        if (!in_grant) begin
          in_grant  = 1;
          dur_cnt   = 0;
          to_at     = 0;
          held_code = o_code;
          if (exp_q.size() == 0) begin
            cur.code = 3'd0;
            cur.dur  = 0;
            cur.to   = 0;
            check("unexpected_grant", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            check("grant_code", o_code, cur.code);
          end
        end else begin
          check("code_stable", o_code, held_code);
        end
        dur_cnt++;
        if (o_timeout) to_at = dur_cnt;
      end else if (in_grant) begin
        in_grant = 0;
        $display("grant code=%0d dur=%0d timeout_at=%0d", held_code, dur_cnt, to_at);
        if (cur.dur != 0) begin
          check("grant_duration", dur_cnt, cur.dur);
          check("timeout_seen", int'(to_at != 0), int'(cur.to));
          if (cur.to) check("timeout_last_cycle", to_at, cur.dur);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req = 8'h00;
    ack = 1'b0;
`ifdef REQ_MASK_EN
    mask = 8'h00;
`endif
    repeat (3) tick();
    check("reset_valid", o_valid, 0);
    check("reset_code", o_code, 0);
    check("reset_pending", o_pending, 0);
    check("reset_timeout", o_timeout, 0);
    rst = 1'b0;
    tick();

    // Single request: pending after one edge, grant after the next edge.
    req = 8'h01;
    tick();
    req = 8'h00;
    check("single_pending", o_pending, 8'h01);
    check("single_not_yet_valid", o_valid, 0);
    push(3'd0, 1, 0);
    grant_ack(1);
    check("single_cleared", o_pending, 8'h00);
    check("single_valid_low", o_valid, 0);
    tick();

    // Two requests in one cycle are granted 5 then 2, with one idle cycle.
    req = 8'h24;
    tick();
    req = 8'h00;
    check("pair_pending", o_pending, 8'h24);
    push(3'd5, 1, 0);
    push(3'd2, 1, 0);
    grant_ack(1);
    check("pair_idle_gap", o_valid, 0);
    tick();
    check("pair_second_valid", o_valid, 1);
    grant_ack(1);
    check("pair_cleared", o_pending, 8'h00);
    tick();

    // Timeout: post bit 6 and never ack. Valid for 4 cycles, pulse on the 4th.
    req = 8'h40;
    tick();
    req = 8'h00;
    push(3'd6, 4, 1);
    wait_valid(1);
    wait_valid(0);
    check("timeout_cleared", o_pending, 8'h00);
    check("timeout_pulse_gone", o_timeout, 0);
    tick();

    // A new edge that arrives in the ack cycle wins over the clear.
    req = 8'h08;
    tick();
    req = 8'h00;
    push(3'd3, 1, 0);
    push(3'd3, 1, 0);
    wait_valid(1);
    ack = 1'b1;
    req = 8'h08;
    tick();
    ack = 1'b0;
    req = 8'h00;
    check("set_wins_pending", o_pending, 8'h08);
    check("set_wins_idle_gap", o_valid, 0);
    tick();
    check("regrant_valid", o_valid, 1);
    grant_ack(1);
    tick();

    // A higher request during a grant does not disturb that grant.
    req = 8'h01;
    tick();
    req = 8'h00;
    push(3'd0, 3, 0);
    push(3'd7, 1, 0);
    wait_valid(1);
    req = 8'h80;
    tick();
    req = 8'h00;
    check("preempt_pending", o_pending, 8'h81);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    grant_ack(1);
    tick();

    // Reset during a grant abandons it and gives no timeout pulse.
    req = 8'h02;
    tick();
    req = 8'h00;
    push(3'd1, 0, 0);
    wait_valid(1);
    tick();
    rst = 1'b1;
    check("reset_in_grant_timeout", o_timeout, 0);
    tick();
    check("abandon_valid", o_valid, 0);
    check("abandon_pending", o_pending, 8'h00);
    check("abandon_timeout", o_timeout, 0);

    // A line held high through reset release does not post a request.
    req = 8'hFF;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    check("held_high_pending", o_pending, 8'h00);
    check("held_high_valid", o_valid, 0);
    req = 8'h00;
    tick();
    req = 8'h80;
    tick();
    req = 8'h00;
    push(3'd7, 1, 0);
    grant_ack(1);
    tick();

    // Ack while idle is ignored.
    ack = 1'b1;
    repeat (2) tick();
    ack = 1'b0;
    check("idle_ack_valid", o_valid, 0);

`ifdef REQ_MASK_EN
    // Masked bit 7 latches but is not granted. Bit 1 is granted instead.
    mask = 8'h80;
    req  = 8'h82;
    tick();
    req = 8'h00;
    check("mask_pending", o_pending, 8'h82);
    push(3'd1, 1, 0);
    grant_ack(1);
    repeat (3) tick();
    check("mask_pending_kept", o_pending, 8'h80);
    check("mask_no_grant", o_valid, 0);
    mask = 8'h00;
    push(3'd7, 1, 0);
    grant_ack(1);
    check("unmask_cleared", o_pending, 8'h00);
    tick();
`endif

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
